// File: rtl/fpu_issue_ctrl_if.sv
// Handshake and FPU-core bundle for fpu_issue_ctrl.
// slave: the controller side; master: the requester/consumer/FPU-model side.
interface fpu_issue_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_opA;
    logic [31:0] req_opB;
    logic [1:0]  req_op;
    logic [31:0] fpu_opA;
    logic [31:0] fpu_opB;
    logic [1:0]  fpu_op;
    logic [31:0] fpu_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [1:0]  rsp_op;
    logic        busy;

    modport slave (
        input  req_valid, req_opA, req_opB, req_op, fpu_out, rsp_ready,
        output req_ready, fpu_opA, fpu_opB, fpu_op, rsp_valid, rsp_result, rsp_op, busy
    );

    modport master (
        output req_valid, req_opA, req_opB, req_op, fpu_out, rsp_ready,
        input  req_ready, fpu_opA, fpu_opB, fpu_op, rsp_valid, rsp_result, rsp_op, busy
    );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FPU issue controller: buffers requests in a FIFO, issues one op at a time to the FPU core,
// holds operands for the op-dependent latency, captures the result and returns it.
// Optional statistics ports (ops_done, max_fifo) are enabled by defining FPU_ISSUE_STATS_EN.
module fpu_issue_ctrl #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADD_LAT    = 1,
    parameter int unsigned MULDIV_LAT = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    fpu_issue_ctrl_if.slave        io
`ifdef FPU_ISSUE_STATS_EN
    ,
    output logic [31:0]            ops_done,
    output logic [$clog2(DEPTH):0] max_fifo
`endif
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [7:0] ADD_LAT_C    = 8'(ADD_LAT);
    localparam logic [7:0] MULDIV_LAT_C = 8'(MULDIV_LAT);

    typedef enum logic [1:0] {StIdle, StExec, StHold} state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
    } req_t;

    state_e          state_q, state_d;
    req_t            mem_q [DEPTH];
    req_t            mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      lat_cnt_q, lat_cnt_d;
    logic [31:0]     fpu_opA_q, fpu_opA_d, fpu_opB_q, fpu_opB_d;
    logic [1:0]      fpu_op_q, fpu_op_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_result_q, rsp_result_d;
    logic [1:0]      rsp_op_q, rsp_op_d;
    logic            push, pop;
    req_t            head;

    assign io.req_ready  = (count_q != CW'(DEPTH));
    assign io.fpu_opA    = fpu_opA_q;
    assign io.fpu_opB    = fpu_opB_q;
    assign io.fpu_op     = fpu_op_q;
    assign io.rsp_valid  = rsp_valid_q;
    assign io.rsp_result = rsp_result_q;
    assign io.rsp_op     = rsp_op_q;
    assign io.busy       = (state_q != StIdle) || (count_q != '0);

    assign push = io.req_valid && io.req_ready;
    assign head = mem_q[rd_ptr_q];

    // FIFO write side and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{a: io.req_opA, b: io.req_opB, op: io.req_op};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Issue FSM: next state, pop decision, operand load and result capture.
    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        fpu_opA_d    = fpu_opA_q;
        fpu_opB_d    = fpu_opB_q;
        fpu_op_d     = fpu_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_op_d     = rsp_op_q;
        pop          = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) pop = 1'b1;
            end
            StExec: begin
                lat_cnt_d = lat_cnt_q - 8'd1;
                if (lat_cnt_q == 8'd1) begin
                    rsp_result_d = io.fpu_out;
                    rsp_op_d     = fpu_op_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = StHold;
                end
            end
            StHold: begin
                if (rsp_valid_q && io.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (count_q != '0) pop = 1'b1;
                    else               state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A pop always starts the next op, whether from IDLE or straight out of HOLD.
        if (pop) begin
            fpu_opA_d = head.a;
            fpu_opB_d = head.b;
            fpu_op_d  = head.op;
            lat_cnt_d = head.op[1] ? MULDIV_LAT_C : ADD_LAT_C;
            state_d   = StExec;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lat_cnt_q    <= '0;
            fpu_opA_q    <= '0;
            fpu_opB_q    <= '0;
            fpu_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            lat_cnt_q    <= lat_cnt_d;
            fpu_opA_q    <= fpu_opA_d;
            fpu_opB_q    <= fpu_opB_d;
            fpu_op_q     <= fpu_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_op_q     <= rsp_op_d;
        end
    end

`ifdef FPU_ISSUE_STATS_EN
    logic [31:0]   ops_done_q, ops_done_d;
    logic [CW-1:0] max_fifo_q, max_fifo_d;

    assign ops_done = ops_done_q;
    assign max_fifo = max_fifo_q;

    // Completed-op counter (wraps) and peak FIFO occupancy since reset.
    always_comb begin
        ops_done_d = ops_done_q;
        max_fifo_d = max_fifo_q;
        if (rsp_valid_q && io.rsp_ready) ops_done_d = ops_done_q + 32'd1;
        if (count_d > max_fifo_q)        max_fifo_d = count_d;
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ops_done_q <= '0;
            max_fifo_q <= '0;
        end else begin
            ops_done_q <= ops_done_d;
            max_fifo_q <= max_fifo_d;
        end
    end
`endif
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl: the driver pushes expected responses (result, opcode,
// push edge) into a queue; a negedge monitor pops and compares every returned response,
// including the edge at which it must first appear.
module tb_fpu_issue_ctrl;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned ADD_LAT    = 1;
    localparam int unsigned MULDIV_LAT = 32;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] res;
        int          push_edge;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   mode = 0;          // 0 ready, 1 random, 2 stalled, 3 hold 10 cycles after capture
    int   last_accept = 0;
    int   n_acc = 0;
    int   hold_cnt = 0;
    bit   seen = 1'b0;
    logic [31:0] held_res;
    logic [1:0]  held_op;
    logic        r;
    exp_t sb[$];

    fpu_issue_ctrl_if dif();

`ifdef FPU_ISSUE_STATS_EN
    logic [31:0]            ops_done;
    logic [$clog2(DEPTH):0] max_fifo;
`endif

    fpu_issue_ctrl #(
        .DEPTH(DEPTH),
        .ADD_LAT(ADD_LAT),
        .MULDIV_LAT(MULDIV_LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io(dif)
`ifdef FPU_ISSUE_STATS_EN
        ,
        .ops_done(ops_done),
        .max_fifo(max_fifo)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // FPU core model: exact IEEE results for the two directed cases, a mixing hash otherwise.
    function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        if (op == 2'b00 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (op == 2'b10 && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        return (a ^ {b[15:0], b[31:16]}) + ({30'd0, op} * 32'h0101_0101);
    endfunction

    assign dif.fpu_out = fpu_model(dif.fpu_opA, dif.fpu_opB, dif.fpu_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare each response on first sight, check hold while stalled, drive rsp_ready.
    always @(negedge clk) begin
        if (reset) begin
            seen = 1'b0;
            dif.rsp_ready = 1'b0;
        end else begin
            if (dif.rsp_valid && !seen) begin
                seen     = 1'b1;
                hold_cnt = 0;
                held_res = dif.rsp_result;
                held_op  = dif.rsp_op;
                if (sb.size() == 0) begin
                    check("unexpected_rsp", {31'd0, dif.rsp_valid}, 32'd0);
                end else begin
                    exp_t e;
                    int   issue;
                    int   lat;
                    e     = sb[0];
                    issue = (e.push_edge + 1 > last_accept) ? e.push_edge + 1 : last_accept;
                    lat   = e.op[1] ? MULDIV_LAT : ADD_LAT;
                    check("rsp_capture_edge", cyc, issue + lat);
                    check("rsp_result", dif.rsp_result, e.res);
                    check("rsp_op", {30'd0, dif.rsp_op}, {30'd0, e.op});
                    check("fpu_opA_held", dif.fpu_opA, e.a);
                end
            end else if (dif.rsp_valid && seen) begin
                hold_cnt++;
                check("rsp_result_hold", dif.rsp_result, held_res);
                check("rsp_op_hold", {30'd0, dif.rsp_op}, {30'd0, held_op});
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                2:       r = 1'b0;
                default: r = (hold_cnt >= 10);
            endcase
            dif.rsp_ready = r;
            if (dif.rsp_valid && r && seen) begin
                if (sb.size() != 0) void'(sb.pop_front());
                last_accept = cyc + 1;
                n_acc++;
                seen = 1'b0;
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the push edge.
    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        int w = 0;
        dif.req_valid = 1'b1;
        dif.req_opA   = a;
        dif.req_opB   = b;
        dif.req_op    = op;
        while (!dif.req_ready && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check("push_timeout", {31'd0, w >= 3000}, 32'd0);
        sb.push_back('{a: a, b: b, op: op, res: fpu_model(a, b, op), push_edge: cyc + 1});
        @(negedge clk);
        dif.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || dif.busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", {31'd0, n >= 5000}, 32'd0);
    endtask

    task automatic apply_reset();
        #2 reset = 1'b1;
        sb.delete();
        last_accept = 0;
        n_acc = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int vcnt;
        dif.req_valid = 1'b0;
        dif.req_opA   = '0;
        dif.req_opB   = '0;
        dif.req_op    = '0;
        dif.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, dif.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, dif.rsp_valid}, 32'd0);
        check("rst_busy", {31'd0, dif.busy}, 32'd0);
        check("rst_fpu_opA", dif.fpu_opA, 32'd0);
        check("rst_rsp_result", dif.rsp_result, 32'd0);
        #2 reset = 1'b0;
        @(negedge clk);

        // Add: operands appear one cycle after the push edge.
        mode = 0;
        push(32'h3F80_0000, 32'h4000_0000, 2'b00);
        @(negedge clk);
        check("add_fpu_opA", dif.fpu_opA, 32'h3F80_0000);
        check("add_fpu_opB", dif.fpu_opB, 32'h4000_0000);
        check("add_fpu_op", {30'd0, dif.fpu_op}, 32'd0);
        drain();

        // Mul: long latency.
        push(32'h4000_0000, 32'h4040_0000, 2'b10);
        drain();

        // FIFO full: one in flight plus DEPTH queued, then a stalled sixth push.
        mode = 2;
        for (int i = 0; i < 5; i++) push($urandom, $urandom, 2'($urandom_range(0, 3)));
        check("fifo_full_ready", {31'd0, dif.req_ready}, 32'd0);
        check("fifo_full_busy", {31'd0, dif.busy}, 32'd1);
        fork
            push(32'h1234_5678, 32'h9ABC_DEF0, 2'b01);
            begin
                repeat (10) @(negedge clk);
                check("fifo_stall_ready", {31'd0, dif.req_ready}, 32'd0);
                mode = 0;
            end
        join
        drain();
        check("fifo_all_returned", n_acc, 8);
`ifdef FPU_ISSUE_STATS_EN
        check("stats_ops_done", ops_done, n_acc);
        check("stats_max_fifo", {29'd0, max_fifo}, DEPTH);
`endif

        // Backpressure: hold rsp_ready low 10 cycles after each capture.
        mode = 3;
        push(32'h0BAD_F00D, 32'h0000_1111, 2'b00);
        push(32'h7777_0000, 32'h0000_2222, 2'b11);
        drain();

        // Randomized traffic with random consumer stalls.
        mode = 1;
        for (int i = 0; i < 30; i++) begin
            push($urandom, $urandom, 2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        mode = 0;
        drain();

        // Reset in the middle of a divide with two requests queued.
        push(32'h4100_0000, 32'h4000_0000, 2'b11);
        push($urandom, $urandom, 2'b00);
        push($urandom, $urandom, 2'b10);
        repeat (12) @(negedge clk);
        check("pre_rst_busy", {31'd0, dif.busy}, 32'd1);
        apply_reset();
        #1;
        check("mid_rst_req_ready", {31'd0, dif.req_ready}, 32'd1);
        check("mid_rst_rsp_valid", {31'd0, dif.rsp_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, dif.busy}, 32'd0);
        check("mid_rst_fpu_opA", dif.fpu_opA, 32'd0);
        check("mid_rst_fpu_op", {30'd0, dif.fpu_op}, 32'd0);
        check("mid_rst_rsp_result", dif.rsp_result, 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        vcnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (dif.rsp_valid) vcnt++;
        end
        check("post_rst_no_rsp", vcnt, 0);
        check("post_rst_busy", {31'd0, dif.busy}, 32'd0);
`ifdef FPU_ISSUE_STATS_EN
        check("post_rst_ops_done", ops_done, 32'd0);
        check("post_rst_max_fifo", {29'd0, max_fifo}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

- Sits between the testbench BFM and the FPU core.
- Accepts operation requests (opA, opB, op) over a valid/ready handshake and buffers them in a small FIFO.
- Issues one operation at a time to the FPU and holds its operands stable for the op-dependent latency.
- Captures the FPU result and returns it over a second valid/ready handshake. The BFM therefore no longer counts wait cycles itself.

## Interface
Parameters:
- DEPTH, 4, request FIFO entries; power of two, ≥2
- ADD_LAT, 1, cycles from issue to capture for add/sub (op[1]=0); ≥1
- MULDIV_LAT, 32, cycles from issue to capture for mul/div (op[1]=1); ≥1, <256

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full
- req_opA  in  32  operand A (IEEE-754 single bits)
- req_opB  in  32  operand B
- req_op  in  2  00 add, 01 sub, 10 mul, 11 div
- fpu_opA  out  32  registered operand A to FPU core
- fpu_opB  out  32  registered operand B to FPU core
- fpu_op  out  2  registered opcode to FPU core
- fpu_out  in  32  FPU core result
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  32  captured fpu_out
- rsp_op  out  2  opcode of the returned result
- busy  out  1  state ≠ IDLE or FIFO non-empty

## Operation

**Request FIFO**
- Push on req_valid && req_ready.
- req_ready = (count != DEPTH).
- Read/write pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
- Push and pop in the same cycle: count unchanged.
- Pushing when full is impossible by handshake; req_valid while full is ignored, no data lost.

**FSM states: IDLE, EXEC, HOLD**

IDLE
- If FIFO non-empty: pop head, load fpu_opA/fpu_opB/fpu_op, load lat_cnt with LAT(op), go to EXEC.
- LAT(op) = op[1] ? MULDIV_LAT : ADD_LAT.

EXEC
- lat_cnt decrements each cycle.
- On the edge where lat_cnt==1: rsp_result←fpu_out, rsp_op←fpu_op, rsp_valid←1, go to HOLD.

HOLD
- rsp_valid, rsp_result and rsp_op hold until rsp_valid && rsp_ready.
- On that edge rsp_valid←0, and:
  - FIFO non-empty: pop and load the next op exactly as in IDLE, go to EXEC (no bubble).
  - FIFO empty: go to IDLE.

**General**
- fpu_opA/fpu_opB/fpu_op change only on a pop; otherwise they hold their last values, including in IDLE.
- Exactly one operation in flight; fpu_out is sampled only at the capture edge.

## Timing
- Reset values:
  - req_ready=1, rsp_valid=0, busy=0.
  - fpu_opA=fpu_opB=0, fpu_op=00, rsp_result=0, rsp_op=00.
  - FIFO empty, state IDLE, lat_cnt=0.
- Reset mid-operation: the in-flight op and all queued requests are discarded; no response is produced.
- Push at edge T into an empty FIFO in IDLE:
  - Pop and issue at edge T+1.
  - Capture at edge T+1+LAT.
  - rsp_valid high from T+1+LAT.
- Back-to-back throughput with rsp_ready tied high: one result every LAT+1 cycles (issue edge plus LAT).
- busy is combinational from state and count.

## Configuration
- Macro `FPU_ISSUE_STATS_EN`.
- Defined:
  - Adds output port ops_done [31:0], reset 0.
  - Increments by 1 on every rsp_valid && rsp_ready; wraps 0xFFFFFFFF→0.
  - Adds output port max_fifo [$clog2(DEPTH):0], reset 0, holding the peak FIFO count since reset.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

## Test plan
- **Add:** reset, push add 3F800000+40000000; FPU model drives 40400000.
  - fpu_* loaded 1 cycle after push.
  - rsp_valid after ADD_LAT more cycles, rsp_result=40400000, rsp_op=00.
- **Mul:** push mul 40000000×40400000, model 40C00000.
  - fpu_* stable for exactly 32 cycles.
  - Capture at edge 33 after push; rsp_op=10.
- **FIFO full:** hold rsp_ready=0, push 6 requests.
  - First one issues; 4 more fill the FIFO and req_ready goes 0.
  - 6th stalls with req_valid held.
  - Release rsp_ready: all 6 responses return in push order, nothing dropped.
- **Backpressure:** rsp_ready=0 for 10 cycles after capture.
  - rsp_valid and rsp_result stay constant.
  - Next op issues on the accept edge.
- **Reset mid-EXEC:** assert reset at cycle 15 of a div with 2 requests queued.
  - All outputs return to reset values immediately.
  - No response ever appears; busy=0 after release.
- **Stats (`FPU_ISSUE_STATS_EN`):** after 5 completed ops, ops_done=5 and max_fifo matches the peak FIFO count.
